fp_accumulator: RTL and testbench
=================================

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning data bit width.
REQ-002 The block SHALL have parameter d, default 16, meaning fractional bit count; it is carried for format documentation only and has no arithmetic effect.
REQ-003 The block SHALL have parameter len, default 8, meaning products per frame; legal range 1..2^16.
REQ-004 The block SHALL have parameter sign, default 1, meaning 1 for signed two's-complement data and 0 for unsigned.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = asserted).
REQ-007 The block SHALL have port recv_val, input, 1 bit, meaning the upstream product on a is valid.
REQ-008 The block SHALL have port recv_rdy, output, 1 bit, meaning the block accepts a this cycle.
REQ-009 The block SHALL have port a, input, n bits, the fixed-point product word from the upstream multiplier.
REQ-010 The block SHALL have port send_val, output, 1 bit, meaning c holds a frame sum.
REQ-011 The block SHALL have port send_rdy, input, 1 bit, meaning downstream takes c this cycle.
REQ-012 The block SHALL have port c, output, n bits, the saturated frame sum.

Function
REQ-013 The block SHALL implement two states, ACC and SEND.
REQ-014 In ACC, recv_rdy SHALL be 1 and send_val SHALL be 0; in SEND, recv_rdy SHALL be 0 and send_val SHALL be 1.
REQ-015 recv_rdy and send_val SHALL depend only on registered state and reset, with no combinational path from recv_val or send_rdy.
REQ-016 An accept SHALL occur on a rising edge in ACC with recv_val=1.
REQ-017 On each accept, the wide accumulator (n+clog2(len)+1 bits) SHALL add a, sign-extended when sign=1 and zero-extended when sign=0, and the counter SHALL increment.
REQ-018 On the accept with counter==len-1, the block SHALL enter SEND and register c = sat(acc + a); the counter and accumulator SHALL then clear to 0.
REQ-019 send_val SHALL rise on the cycle after the len-th accept; latency from the final accept to valid c is 1 cycle.
REQ-020 When sign=1, sat SHALL clamp sums above 2^(n-1)-1 to 0x7FFF_FFFF and sums below -2^(n-1) to 0x8000_0000 (n=32 values); otherwise it SHALL truncate to n bits unchanged.
REQ-021 When sign=0, sat SHALL clamp sums above 2^n-1 to all ones.
REQ-022 In SEND, c SHALL hold stable while send_rdy=0, and recv_val SHALL be ignored.
REQ-023 In SEND with send_rdy=1, the block SHALL return to ACC on the next edge; the earliest next accept is the cycle after the handoff.
REQ-024 With len=1, every accept SHALL go directly to SEND with c = sat(a).
REQ-025 Saturation SHALL apply only to the final sum; intermediate accumulation SHALL never wrap for legal len.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force state=ACC, accumulator=0, counter=0, c=0, send_val=0, and recv_rdy=0.
REQ-027 After reset returns to 1, recv_rdy SHALL read 1 in the same cycle.
REQ-028 Reset asserted mid-frame or in SEND SHALL discard the partial sum and any pending c; no output handshake SHALL occur for that frame.

Verification (n=32, d=16, len=4, sign=1 unless stated)
REQ-029 Test 1: four accepts of 0x00010000 -> send_val=1 one cycle after the 4th accept, c=0x00040000.
REQ-030 Test 2: inputs 0xFFFF0000, 0xFFFF0000, 0x00030000, 0x00030000 -> c=0x00040000.
REQ-031 Test 3: four 0x7FFFFFFF -> c=0x7FFFFFFF; four 0x80000000 -> c=0x80000000.
REQ-032 Test 4: with send_rdy held 0 for 5 cycles after valid, recv_val=1 with changing a -> c constant, recv_rdy=0, and the next frame result unaffected.
REQ-033 Test 5: two accepts, reset pulsed low, then four 0x00010000 -> c=0x00040000, and no send_val occurs before the 4th post-reset accept.
REQ-034 Test 6: len=1, sign=0, input 0xFFFFFFFF, then 0x00000005 back-to-back with send_rdy=1 -> c=0xFFFFFFFF then c=0x00000005, with 2 cycles per item.

Source files
------------

// File: rtl/fp_accumulator.sv
// Fixed-point frame accumulator: sums len product words from an upstream
// multiplier into a wide accumulator, then presents the saturated n-bit
// frame sum on c until downstream takes it.
//
// Handshake: a word on 'a' transfers on a rising edge where recv_val and
// recv_rdy are both 1; the frame sum on 'c' transfers on a rising edge
// where send_val and send_rdy are both 1. recv_rdy and send_val are
// functions of registered state (and reset) only, so neither ready nor
// valid ever depends combinationally on the other side's signal.
module fp_accumulator #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int len  = 8,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c,
  output logic         dbg_state
);

  // Counter must reach len-1; keep at least one bit so len=1 still elaborates.
  localparam int CW = (len > 1) ? $clog2(len) : 1;
  // One guard bit beyond the len-fold growth so no legal frame can wrap.
  localparam int AW = n + $clog2(len) + 1;
  localparam logic [CW-1:0] LAST = CW'(len - 1);

  typedef enum logic {
    ACC  = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] a_ext;
  logic [AW-1:0] sum;
  logic [n-1:0]  sat_sum;
  logic [AW-n:0] sum_hi_s;  // sum[AW-1:n-1], must be all-equal to fit signed
  logic [AW-n-1:0] sum_hi_u; // sum[AW-1:n], must be zero to fit unsigned

  // d only documents the binary point; it never touches the datapath.
  logic unused_frac_param;
  assign unused_frac_param = (d >= 0);

  // Extend the incoming word to accumulator width and form the running sum.
  always_comb begin
    a_ext = '0;
    if (sign != 0) begin
      a_ext = {{(AW-n){a[n-1]}}, a};
    end else begin
      a_ext = {{(AW-n){1'b0}}, a};
    end
    sum = acc + a_ext;
  end

  assign sum_hi_s = sum[AW-1:n-1];
  assign sum_hi_u = sum[AW-1:n];

  // Saturate the wide sum back to n bits; only the final frame sum uses this.
  always_comb begin
    sat_sum = sum[n-1:0];
    if (sign != 0) begin
      if (!((&sum_hi_s) || !(|sum_hi_s))) begin
        sat_sum = sum[AW-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      end
    end else begin
      if (|sum_hi_u) begin
        sat_sum = '1;
      end
    end
  end

  // Frame FSM: accumulate len accepts, then hold c until it is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      c     <= '0;
    end else begin
      case (state)
        ACC: begin
          if (recv_val) begin
            if (cnt == LAST) begin
              c     <= sat_sum;
              acc   <= '0;
              cnt   <= '0;
              state <= SEND;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        SEND: begin
          if (send_rdy) begin
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 throughout reset and 1 right after.
  assign recv_rdy  = reset && (state == ACC);
  assign send_val  = (state == SEND);
  assign dbg_state = (state == SEND);

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: a signed len=4 instance and an unsigned len=1
// instance share clock and reset. Drivers push expected frame sums into
// per-instance queues; monitors pop and compare on every output handshake.
module tb_fp_accumulator;

  localparam int N = 32;

  logic          clk;
  logic          reset;
  logic          recv_val0, recv_rdy0, send_val0, send_rdy0, dbg0;
  logic [N-1:0]  a0, c0;
  logic          recv_val1, recv_rdy1, send_val1, send_rdy1, dbg1;
  logic [N-1:0]  a1, c1;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  bit rand_rdy0  = 0;

  logic [N-1:0] exp_q0[$];
  logic [N-1:0] exp_q1[$];
  logic [N-1:0] frame0[$];

  fp_accumulator #(.n(32), .d(16), .len(4), .sign(1)) dut0 (
    .clk(clk), .reset(reset), .recv_val(recv_val0), .recv_rdy(recv_rdy0),
    .a(a0), .send_val(send_val0), .send_rdy(send_rdy0), .c(c0),
    .dbg_state(dbg0)
  );

  fp_accumulator #(.n(32), .d(16), .len(1), .sign(0)) dut1 (
    .clk(clk), .reset(reset), .recv_val(recv_val1), .recv_rdy(recv_rdy1),
    .a(a1), .send_val(send_val1), .send_rdy(send_rdy1), .c(c1),
    .dbg_state(dbg1)
  );

  // Clock and cycle counter.
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the frame, then clamp to the n-bit range.
  function automatic logic [N-1:0] ref_sum(input logic [N-1:0] items[$], input bit is_signed);
    longint total = 0;
    logic [63:0] t64;
    for (int i = 0; i < items.size(); i++) begin
      if (is_signed) total += longint'($signed(items[i]));
      else           total += longint'({32'd0, items[i]});
    end
    if (is_signed) begin
      if (total > 64'sd2147483647)       return 32'h7FFF_FFFF;
      else if (total < -64'sd2147483648) return 32'h8000_0000;
    end else begin
      if (total > 64'sd4294967295)       return 32'hFFFF_FFFF;
    end
    t64 = total;
    return t64[31:0];
  endfunction

  // Drive one word into the signed instance and wait (bounded) for its accept.
  task automatic push0(input logic [N-1:0] v);
    int  waited = 0;
    bit  done = 0;
    @(posedge clk); #1;
    recv_val0 = 1;
    a0 = v;
    @(negedge clk);
    while (!recv_rdy0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!recv_rdy0) begin
      check("push0_timeout", 32'(recv_rdy0), 32'd1);
      recv_val0 = 0;
      return;
    end
    frame0.push_back(v);
    if (frame0.size() == 4) begin
      exp_q0.push_back(ref_sum(frame0, 1'b1));
      frame0.delete();
      done = 1;
    end
    @(posedge clk); #1;
    recv_val0 = 0;
    @(negedge clk);
    check("send_val_after_accept", 32'(send_val0), 32'(done));
  endtask

  // Drive one word into the len=1 instance, leaving recv_val high for back-to-back use.
  task automatic push1(input logic [N-1:0] v, output int acc_cyc);
    int waited = 0;
    recv_val1 = 1;
    a1 = v;
    acc_cyc = -1;
    @(negedge clk);
    while (!recv_rdy1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!recv_rdy1) begin
      check("push1_timeout", 32'(recv_rdy1), 32'd1);
      return;
    end
    exp_q1.push_back(ref_sum('{v}, 1'b0));
    acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  // Monitor for the signed instance.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && send_val0 && send_rdy0) begin
        if (exp_q0.size() == 0) check("unexpected_send0", 32'(send_val0), 32'd0);
        else check("frame_sum0", c0, exp_q0.pop_front());
      end
    end
  end

  // Monitor for the unsigned len=1 instance.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && send_val1 && send_rdy1) begin
        if (exp_q1.size() == 0) check("unexpected_send1", 32'(send_val1), 32'd0);
        else check("frame_sum1", c1, exp_q1.pop_front());
      end
    end
  end

  // Random backpressure on the signed instance during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy0) send_rdy0 = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 0;
    #1;
    check("rst_recv_rdy0", 32'(recv_rdy0), 32'd0);
    check("rst_send_val0", 32'(send_val0), 32'd0);
    check("rst_c0", c0, 32'd0);
    check("rst_recv_rdy1", 32'(recv_rdy1), 32'd0);
    frame0.delete();
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset = 1;
    #1;
    check("post_rst_recv_rdy0", 32'(recv_rdy0), 32'd1);
  endtask

  initial begin
    int t0, t1;
    logic [N-1:0] r;
    reset = 0;
    recv_val0 = 0; a0 = '0; send_rdy0 = 1;
    recv_val1 = 0; a1 = '0; send_rdy1 = 1;
    #1;
    check("init_recv_rdy0", 32'(recv_rdy0), 32'd0);
    check("init_send_val0", 32'(send_val0), 32'd0);
    check("init_c0", c0, 32'd0);
    check("init_send_val1", 32'(send_val1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset = 1;
    #1;
    check("release_recv_rdy0", 32'(recv_rdy0), 32'd1);
    check("release_recv_rdy1", 32'(recv_rdy1), 32'd1);

    // Simple sums, mixed signs, both saturation directions.
    repeat (4) push0(32'h0001_0000);
    push0(32'hFFFF_0000); push0(32'hFFFF_0000);
    push0(32'h0003_0000); push0(32'h0003_0000);
    repeat (4) push0(32'h7FFF_FFFF);
    repeat (4) push0(32'h8000_0000);

    // Output stall: c must hold and new words must be refused.
    @(posedge clk); #1;
    send_rdy0 = 0;
    repeat (4) push0(32'h0002_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      recv_val0 = 1;
      a0 = $urandom;
      @(negedge clk);
      check("stall_recv_rdy0", 32'(recv_rdy0), 32'd0);
      check("stall_dbg_state0", 32'(dbg0), 32'd1);
      if (exp_q0.size() > 0) check("stall_c_hold", c0, exp_q0[0]);
    end
    @(posedge clk); #1;
    recv_val0 = 0;
    send_rdy0 = 1;
    push0(32'h0000_0001); push0(32'h0000_0002);
    push0(32'h0000_0003); push0(32'h0000_0004);

    // Reset mid-frame discards the partial sum.
    push0(32'h1234_0000); push0(32'h0567_0000);
    do_reset();
    repeat (4) push0(32'h0001_0000);

    // Reset while holding a result discards it.
    @(posedge clk); #1;
    send_rdy0 = 0;
    repeat (4) push0(32'h0009_0000);
    do_reset();
    @(negedge clk);
    check("discarded_send_val0", 32'(send_val0), 32'd0);
    @(posedge clk); #1;
    send_rdy0 = 1;
    repeat (4) push0(32'hFFFF_FFFF);

    // Random frames with random backpressure.
    rand_rdy0 = 1;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: r = $urandom;
          1: r = 32'h7FFF_FF00 + $urandom_range(0, 255);
          2: r = 32'h8000_0000 + $urandom_range(0, 255);
          default: r = $urandom_range(0, 65535) - 32'd32768;
        endcase
        push0(r);
      end
    end
    rand_rdy0 = 0;
    @(posedge clk); #1;
    send_rdy0 = 1;

    // len=1 unsigned: back-to-back accepts two cycles apart.
    @(posedge clk); #1;
    send_rdy1 = 1;
    push1(32'hFFFF_FFFF, t0);
    push1(32'h0000_0005, t1);
    check("len1_cycles_per_item", 32'(t1 - t0), 32'd2);
    for (int i = 0; i < 4; i++) begin
      push1($urandom, t0);
    end
    recv_val1 = 0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
